// File: rtl/swim_pkg.sv
// swim_pkg: shared state encoding and SWIM timing/pattern constants.
package swim_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    localparam int SWIM_DIV_250US = 12000;
    localparam int SWIM_RST_LEN = 36;
    // 500 us low/high pairs, 250 us low/high pairs, then released tail
    localparam logic [35:0] SWIM_RST_PATTERN = 36'h333355FFF;

endpackage

// File: rtl/swim_tick_div.sv
// swim_tick_div: bit-period counter running 0..DIV-1 with a one-cycle tick at DIV-1.
module swim_tick_div
    import swim_pkg::*;
#(
    parameter int DIV   = SWIM_DIV_250US,
    parameter int DIV_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic             tick,
    output logic [DIV_W-1:0] count
);

    assign tick = en && count == DIV_W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (!reset || clear)
            count <= '0;
        else if (en)
            count <= tick ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/swim_seq.sv
// swim_seq: shifts a loaded pattern MSB-first onto an open-drain SWIM line, with repeats, gaps and abort.
// Line sampling into sample_data is built only when SWIM_SEQ_SAMPLE_EN is defined.
module swim_seq
    import swim_pkg::*;
#(
    parameter int PATTERN_W = 36,
    parameter int LEN_W     = 6,
    parameter int DIV       = SWIM_DIV_250US,
    parameter int DIV_W     = 14,
    parameter int REP_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [LEN_W-1:0]     length,
    input  logic [REP_W-1:0]     repeats,
    input  logic                 abort,
    output logic                 swim_oe,
    input  logic                 swim_in,
    output logic                 busy,
    output logic                 done,
    output logic [PATTERN_W-1:0] sample_data,
    output logic                 sample_valid
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PATTERN_W);

    state_t               state, state_n;
    logic [PATTERN_W-1:0] pat;
    logic [LEN_W-1:0]     len, idx, idx_n, last;
    logic [REP_W-1:0]     rep, rep_n;
    logic [DIV_W-1:0]     count;
    logic                 oe_n, tick, accept, len_ok;

    assign accept      = start_valid && state == IDLE;
    assign len_ok      = length != '0 && length <= MAX_LEN;
    assign last        = len - 1'b1;
    assign busy        = state != IDLE;
    assign start_ready = state == IDLE;
    assign done        = state == FIN;

    swim_tick_div #(.DIV(DIV), .DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE || state == FIN),
        .en    (state == SEND || state == GAP),
        .tick  (tick),
        .count (count)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        rep_n   = rep;
        oe_n    = swim_oe;
        case (state)
            IDLE: begin
                oe_n = 1'b0;
                if (start_valid) begin
                    state_n = len_ok ? SEND : FIN;
                    idx_n   = length - 1'b1;
                    rep_n   = repeats == '0 ? REP_W'(1) : repeats;
                    oe_n    = len_ok & ~pattern[idx_n];
                end
            end
            SEND: if (tick) begin
                if (idx != '0) begin
                    idx_n = idx - 1'b1;
                    oe_n  = ~pat[idx_n];
                end else begin
                    state_n = rep > REP_W'(1) ? GAP : FIN;
                    rep_n   = rep - 1'b1;
                    oe_n    = 1'b0;
                end
            end
            GAP: if (tick) begin
                state_n = SEND;
                idx_n   = last;
                oe_n    = ~pat[last];
            end
            default: begin
                state_n = IDLE;
                oe_n    = 1'b0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            swim_oe <= 1'b0;
            idx     <= '0;
            rep     <= '0;
            pat     <= '0;
            len     <= '0;
        end else begin
            state   <= state_n;
            swim_oe <= oe_n;
            idx     <= idx_n;
            rep     <= rep_n;
            if (accept) begin
                pat <= pattern;
                len <= length;
            end
        end
    end

`ifdef SWIM_SEQ_SAMPLE_EN
    logic [1:0] sync;

    // swim_in is asynchronous; sample mid-bit once it has crossed the synchroniser
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync        <= '0;
            sample_data <= '0;
        end else begin
            sync <= {sync[0], swim_in};
            if (accept)
                sample_data <= '0;
            else if (state == SEND && count == DIV_W'(DIV / 2))
                sample_data <= {sample_data[PATTERN_W-2:0], sync[1]};
        end
    end

    assign sample_valid = done;
`else
    logic unused_in;
    assign unused_in    = ^{swim_in, count};
    assign sample_data  = '0;
    assign sample_valid = 1'b0;
`endif

endmodule

// File: tb/tb_swim_seq.sv
// tb_swim_seq: scoreboard bench for swim_seq with a 4-cycle bit period and a target echo on swim_in.
module tb_swim_seq;
    import swim_pkg::*;

    localparam int PW = 36;
    localparam int LW = 6;
    localparam int D  = 4;
    localparam int RW = 4;
`ifdef SWIM_SEQ_SAMPLE_EN
    localparam bit SAMPLE = 1'b1;
`else
    localparam bit SAMPLE = 1'b0;
`endif

    typedef struct packed {
        logic oe;
        logic busy;
        logic done;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b0, start_valid = 1'b0, abort = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [LW-1:0] length = '0;
    logic [RW-1:0] repeats = '0;
    logic          start_ready, swim_oe, swim_in, busy, done, sample_valid;
    logic [PW-1:0] sample_data;
    exp_t          exp_q[$];
    int            total = 0, bad = 0;

    swim_seq #(.PATTERN_W(PW), .LEN_W(LW), .DIV(D), .DIV_W(3), .REP_W(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .pattern      (pattern),
        .length       (length),
        .repeats      (repeats),
        .abort        (abort),
        .swim_oe      (swim_oe),
        .swim_in      (swim_in),
        .busy         (busy),
        .done         (done),
        .sample_data  (sample_data),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;
    assign swim_in = ~swim_oe;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Called at a negedge with the DUT idle; returns at the negedge of cycle T+1.
    task automatic start(input logic [PW-1:0] p, input int l, input int r, input logic ab);
        int rr = (r == 0) ? 1 : r;
        start_valid = 1'b1;
        pattern     = p;
        length      = LW'(l);
        repeats     = RW'(r);
        abort       = ab;
        if (l != 0 && l <= PW) begin
            for (int k = 0; k < rr; k++) begin
                for (int i = l - 1; i >= 0; i--)
                    repeat (D) exp_q.push_back(exp_t'{~p[i], 1'b1, 1'b0});
                if (k < rr - 1)
                    repeat (D) exp_q.push_back(exp_t'{1'b0, 1'b1, 1'b0});
            end
        end
        exp_q.push_back(exp_t'{1'b0, 1'b1, 1'b1});
        exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start_valid = 1'b0;
        abort       = 1'b0;
        pattern     = {$urandom, $urandom};
        length      = LW'($urandom);
        repeats     = RW'($urandom);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({swim_oe, busy, done, start_ready, sample_valid, sample_data} !== {5'b00010, {PW{1'b0}}}) begin
            bad++;
            $display("FAIL reset oe/busy/done/ready/sv=%b%b%b%b%b data=%h want 00010 data=0",
                     swim_oe, busy, done, start_ready, sample_valid, sample_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        logic [PW-1:0] tp[7] = '{36'h6, 36'h1, 36'h0, 36'hF, 36'h5, SWIM_RST_PATTERN, 36'h6};
        int tl[7] = '{4, 2, 0, 37, 3, SWIM_RST_LEN, 4};
        int tr[7] = '{1, 3, 1, 1, 0, 1, 1};
        logic ta[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int n = 0; n < 7; n++) begin
            int   dones = 0, act = 0, rr = (tr[n] == 0) ? 1 : tr[n];
            int   want_act = (tl[n] != 0 && tl[n] <= PW) ? tl[n] * D * rr + D * (rr - 1) : 0;
            int   cyc = 1;
            exp_t e;
            start(tp[n], tl[n], tr[n], ta[n]);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if ({swim_oe, busy, done, start_ready, sample_valid} !== {e.oe, e.busy, e.done, ~e.busy, SAMPLE & e.done}) begin
                    bad++;
                    $display("FAIL pattern%0d cycle T+%0d oe/busy/done/ready/sv=%b%b%b%b%b want %b%b%b%b%b", n, cyc,
                             swim_oe, busy, done, start_ready, sample_valid, e.oe, e.busy, e.done, ~e.busy, SAMPLE & e.done);
                end
                dones += int'(done);
                act   += int'(busy & ~done);
                cyc++;
                @(negedge clk);
            end
            total++;
            if (dones != 1) begin
                bad++;
                $display("FAIL pattern%0d done_count got %0d want 1", n, dones);
            end
            total++;
            if (act != want_act) begin
                bad++;
                $display("FAIL pattern%0d active_cycles got %0d want %0d", n, act, want_act);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        start(36'h1, 2, 3, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            e = exp_q.pop_front();
            total++;
            if ({swim_oe, busy, done} !== {e.oe, e.busy, e.done}) begin
                bad++;
                $display("FAIL abort_run cycle T+%0d oe/busy/done=%b%b%b want %b%b%b", c, swim_oe, busy, done, e.oe, e.busy, e.done);
            end
            if (c < 14) @(negedge clk);
        end
        exp_q.delete();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({swim_oe, busy, done, start_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL abort_stop oe/busy/done/ready=%b%b%b%b want 0001", swim_oe, busy, done, start_ready);
        end
        start_valid = 1'b1;
        pattern     = 36'h7;
        length      = 6'd3;
        repeats     = 4'd1;
        @(negedge clk);
        start_valid = 1'b0;
        total++;
        if ({busy, swim_oe} !== 2'b10) begin
            bad++;
            $display("FAIL abort_restart busy/oe=%b%b want 10", busy, swim_oe);
        end
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart_finish busy=%b want 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start(36'h0, 4, 1, 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if ({busy, swim_oe} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_pre busy/oe=%b%b want 11", busy, swim_oe);
        end
        exp_q.delete();
        reset       = 1'b0;
        start_valid = 1'b1;
        pattern     = 36'h0;
        length      = 6'd4;
        @(negedge clk);
        total++;
        if ({swim_oe, busy, done, start_ready, sample_valid, sample_data} !== {5'b00010, {PW{1'b0}}}) begin
            bad++;
            $display("FAIL rstmid_reset oe/busy/done/ready/sv=%b%b%b%b%b data=%h want 00010 data=0",
                     swim_oe, busy, done, start_ready, sample_valid, sample_data);
        end
        @(negedge clk);
        reset       = 1'b1;
        start_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, swim_oe, start_ready} !== 3'b001) begin
            bad++;
            $display("FAIL rstmid_no_accept busy/oe/ready=%b%b%b want 001", busy, swim_oe, start_ready);
        end
    endtask

    task automatic test_sample();
        logic [PW-1:0] want = SAMPLE ? 36'hA : 36'h0;
        start(36'hA, 4, 1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        total++;
        if ({done, sample_valid} !== {1'b1, SAMPLE}) begin
            bad++;
            $display("FAIL sample_pulse done/sv=%b%b want 1%b", done, sample_valid, SAMPLE);
        end
        total++;
        if (sample_data !== want) begin
            bad++;
            $display("FAIL sample_data got %h want %h", sample_data, want);
        end
        @(negedge clk);
        total++;
        if ({sample_valid, sample_data} !== {1'b0, want}) begin
            bad++;
            $display("FAIL sample_hold sv=%b data=%h want 0 %h", sample_valid, sample_data, want);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_abort();
        test_reset_mid();
        test_sample();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
